module_keypad_scanner: RTL and testbench

Input-side counterpart of the display time-multiplexer: scans a 4×4 matrix keypad by driving one column low at a time, samples the rows, debounces, and outputs a 4-bit hex key code with a one-cycle valid strobe. It feeds the digit registers that the display mux reads, closing the keypad → register → 7-segment path.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/module_sync2.sv | 24 ++
 rtl/module_keypad_scanner.sv | 133 +++++++++++++
 tb/tb_module_keypad_scanner.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and decode helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Nibble i holds the code for row = i/4, col = i%4.
    // Rows from r3 (top nibbles) down to r0 (low nibbles): "* 0 # D", "7 8 9 C", "4 5 6 B", "1 2 3 A".
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // Rows are active low; the lowest-index low row wins when several are pulled.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else if (!rows[3]) begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/module_sync2.sv
// rtl/module_sync2.sv - two-flop synchronizer resetting to all ones
module module_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of an asynchronous bus; idle value is all ones (pulled-up rows).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_keypad_scanner.sv
// rtl/module_keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module module_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    state_t            state, state_n;
    logic [1:0]        col, col_n;
    logic [1:0]        lat_row, lat_row_n;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_n;
    logic [3:0]        row_s;
    logic              lat_bit;
    logic              accept;
    logic              release_done;

    module_sync2 #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_i),
        .q     (row_s)
    );

    assign lat_bit = row_s[lat_row];
    assign col_o   = ~(4'b0001 << col);

    // State, column, latched row and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SCAN;
            col      <= 2'd0;
            lat_row  <= 2'd0;
            scan_cnt <= '0;
            deb_cnt  <= '0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            lat_row  <= lat_row_n;
            scan_cnt <= scan_cnt_n;
            deb_cnt  <= deb_cnt_n;
        end
    end

    // Next state; counters default to zero so any state change clears them.
    always_comb begin
        state_n      = state;
        col_n        = col;
        lat_row_n    = lat_row;
        scan_cnt_n   = '0;
        deb_cnt_n    = '0;
        accept       = 1'b0;
        release_done = 1'b0;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    if (row_s != 4'hF) begin
                        state_n   = DEB_PRESS;
                        lat_row_n = lowest_low_row(row_s);
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (lat_bit) begin
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n = PRESSED;
                    accept  = 1'b1;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (lat_bit) begin
                    state_n = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (!lat_bit) begin
                    state_n = PRESSED;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n      = SCAN;
                    col_n        = col + 2'd1;
                    release_done = 1'b1;
                end else begin
                    deb_cnt_n = deb_cnt + 1'b1;
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    // Output registers: pulse and code update only on the DEB_PRESS -> PRESSED transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_o  <= 4'h0;
            key_valid_o <= 1'b0;
            key_held_o  <= 1'b0;
        end else begin
            key_valid_o <= accept;
            if (accept) begin
                key_code_o <= decode_key(lat_row, col);
                key_held_o <= 1'b1;
            end else if (release_done) begin
                key_held_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb/tb_module_keypad_scanner.sv - directed self-checking bench for the keypad scanner
module tb_module_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [3:0]  key_code_o;
    logic        key_valid_o;
    logic        key_held_o;
    logic [15:0] keys = 16'h0000;

    int tests = 0;
    int fails = 0;
    int pulse_count = 0;
    int consec = 0;
    logic prev_valid = 1'b0;

    module_keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

    always #5 clk = ~clk;

    // Matrix model: key index r*4+c pulls row r low while column c is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_i[r] = ~|(keys[r*4 +: 4] & ~col_o);
        end
    end

    always @(negedge clk) begin
        if (key_valid_o) pulse_count++;
        if (prev_valid && key_valid_o) consec++;
        prev_valid = key_valid_o;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int budget, output bit got);
        int i;
        got = 1'b0;
        i = 0;
        while (!got && i < budget) begin
            @(negedge clk);
            if (key_valid_o) got = 1'b1;
            i++;
        end
    endtask

    task automatic wait_release(input int budget, output bit got);
        int i;
        got = 1'b0;
        i = 0;
        while (!got && i < budget) begin
            @(negedge clk);
            if (!key_held_o) got = 1'b1;
            i++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        keys  = 16'h0000;
        tick(2);
        tests++; if (col_o !== 4'b1110) begin fails++; $display("FAIL reset_col got %b want 1110", col_o); end
        tests++; if (key_code_o !== 4'h0) begin fails++; $display("FAIL reset_code got %h want 0", key_code_o); end
        tests++; if (key_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", key_valid_o); end
        tests++; if (key_held_o !== 1'b0) begin fails++; $display("FAIL reset_held got %b want 0", key_held_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan;
        int p0;
        p0 = pulse_count;
        tick(3);
        tests++; if (col_o !== 4'b1110) begin fails++; $display("FAIL idle_col0 got %b want 1110", col_o); end
        tick(1);
        tests++; if (col_o !== 4'b1101) begin fails++; $display("FAIL idle_col1 got %b want 1101", col_o); end
        tick(4);
        tests++; if (col_o !== 4'b1011) begin fails++; $display("FAIL idle_col2 got %b want 1011", col_o); end
        tick(4);
        tests++; if (col_o !== 4'b0111) begin fails++; $display("FAIL idle_col3 got %b want 0111", col_o); end
        tick(4);
        tests++; if (col_o !== 4'b1110) begin fails++; $display("FAIL idle_wrap got %b want 1110", col_o); end
        tests++; if (pulse_count !== p0) begin fails++; $display("FAIL idle_pulses got %0d want %0d", pulse_count, p0); end
    endtask

    task automatic test_press_5;
        int p0;
        int i;
        i = 0;
        while (col_o !== 4'b1101 && i < 20) begin
            tick(1);
            i++;
        end
        tests++; if (col_o !== 4'b1101) begin fails++; $display("FAIL press5_col_wait got %b want 1101", col_o); end
        p0 = pulse_count;
        keys[5] = 1'b1;
        tick(40);
        tests++; if (pulse_count - p0 !== 1) begin fails++; $display("FAIL press5_pulses got %0d want 1", pulse_count - p0); end
        tests++; if (key_code_o !== 4'h5) begin fails++; $display("FAIL press5_code got %h want 5", key_code_o); end
        tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL press5_held got %b want 1", key_held_o); end
        keys[5] = 1'b0;
        tick(10);
        tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL press5_held_late got %b want 1", key_held_o); end
        tick(1);
        tests++; if (key_held_o !== 1'b0) begin fails++; $display("FAIL press5_release got %b want 0", key_held_o); end
        tests++; if (col_o !== 4'b1011) begin fails++; $display("FAIL press5_resume_col got %b want 1011", col_o); end
        tests++; if (pulse_count - p0 !== 1) begin fails++; $display("FAIL press5_total_pulses got %0d want 1", pulse_count - p0); end
    endtask

    task automatic test_bounce;
        int p0;
        int i;
        logic [3:0] c1;
        i = 0;
        while (col_o !== 4'b1101 && i < 20) begin
            tick(1);
            i++;
        end
        p0 = pulse_count;
        repeat (3) begin
            keys[5] = 1'b1;
            tick(3);
            keys[5] = 1'b0;
            tick(5);
        end
        tick(20);
        tests++; if (pulse_count !== p0) begin fails++; $display("FAIL bounce_pulses got %0d want %0d", pulse_count, p0); end
        tests++; if (key_code_o !== 4'h5) begin fails++; $display("FAIL bounce_code got %h want 5", key_code_o); end
        tests++; if (key_held_o !== 1'b0) begin fails++; $display("FAIL bounce_held got %b want 0", key_held_o); end
        c1 = col_o;
        tick(4);
        tests++; if (col_o === c1) begin fails++; $display("FAIL bounce_scan got %b want not %b", col_o, c1); end
    endtask

    task automatic test_release_bounce;
        int p0;
        bit got;
        p0 = pulse_count;
        keys[14] = 1'b1;
        wait_pulse(60, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL hash_pulse got %b want 1", got); end
        tests++; if (key_code_o !== 4'hF) begin fails++; $display("FAIL hash_code got %h want f", key_code_o); end
        tick(3);
        repeat (3) begin
            keys[14] = 1'b0;
            repeat (3) begin
                tick(1);
                tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL hash_bounce_held got %b want 1", key_held_o); end
            end
            keys[14] = 1'b1;
            repeat (2) begin
                tick(1);
                tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL hash_bounce_held got %b want 1", key_held_o); end
            end
        end
        keys[14] = 1'b0;
        tick(8);
        tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL hash_held_before_clean got %b want 1", key_held_o); end
        wait_release(10, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL hash_release got %b want 1", got); end
        tests++; if (pulse_count - p0 !== 1) begin fails++; $display("FAIL hash_pulses got %0d want 1", pulse_count - p0); end
        tests++; if (key_code_o !== 4'hF) begin fails++; $display("FAIL hash_code_hold got %h want f", key_code_o); end
    endtask

    task automatic test_simultaneous;
        bit got;
        keys[4] = 1'b1;
        keys[8] = 1'b1;
        wait_pulse(60, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL multi_pulse got %b want 1", got); end
        tests++; if (key_code_o !== 4'h4) begin fails++; $display("FAIL multi_code got %h want 4", key_code_o); end
        keys = 16'h0000;
        wait_release(30, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL multi_release got %b want 1", got); end
    endtask

    task automatic test_reset_mid_press;
        bit got;
        keys[5] = 1'b1;
        wait_pulse(60, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL rstmid_first_pulse got %b want 1", got); end
        tick(3);
        tests++; if (key_held_o !== 1'b1) begin fails++; $display("FAIL rstmid_held got %b want 1", key_held_o); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (col_o !== 4'b1110) begin fails++; $display("FAIL rstmid_col got %b want 1110", col_o); end
        tests++; if (key_code_o !== 4'h0) begin fails++; $display("FAIL rstmid_code got %h want 0", key_code_o); end
        tests++; if (key_held_o !== 1'b0) begin fails++; $display("FAIL rstmid_held_clr got %b want 0", key_held_o); end
        tests++; if (key_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", key_valid_o); end
        tick(2);
        rst_n = 1'b1;
        wait_pulse(60, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL rstmid_new_pulse got %b want 1", got); end
        tests++; if (key_code_o !== 4'h5) begin fails++; $display("FAIL rstmid_code_after got %h want 5", key_code_o); end
        keys = 16'h0000;
        wait_release(30, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL rstmid_release got %b want 1", got); end
    endtask

    task automatic test_back_to_back;
        tests++; if (consec !== 0) begin fails++; $display("FAIL back_to_back got %0d want 0", consec); end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_5();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
